// File: rtl/doodle_pkg.sv
// Shared types and constants for the platform-scroll datapath.
//   SCREEN_W / SCREEN_H / PLAT_W : screen and platform geometry in pixels
//   plat_t                       : one platform slot as stored in the platform RAM, {x, y}
//   psc_state_t                  : plat_scroll_ctrl sequencer states
//   clamp_dy / wrap_x            : small arithmetic helpers used by the sequencer
package doodle_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PLAT_W   = 64;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } plat_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } psc_state_t;

  // Limit the scroll step to one screen height minus one, so that a single
  // subtraction of the screen height always brings a respawned y back on screen.
  function automatic logic [9:0] clamp_dy(input logic [9:0] dy, input logic [9:0] h_max);
    return (dy > h_max) ? h_max : dy;
  endfunction

  // Fold a 10-bit random value into the legal x range [0, x_max].
  // x_max >= 512 guarantees one subtraction is enough.
  function automatic logic [9:0] wrap_x(input logic [9:0] r, input logic [9:0] x_max);
    return (r > x_max) ? (r - x_max - 10'd1) : r;
  endfunction

endpackage

// File: rtl/plat_lfsr.sv
// 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1 (maximal length, period 1023).
// Advances on every clock edge while out of reset.
//   Clock   : system clock
//   Reset_n : synchronous active-low reset, loads SEED
//   q       : current LFSR state
module plat_lfsr #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       Clock,
  input  logic       Reset_n,
  output logic [9:0] q
);

  logic [9:0] lfsr_q;
  logic [9:0] lfsr_d;

  // Shift left; feedback is the XOR of stages 10 and 7.
  always_comb begin
    lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/plat_scroll_ctrl.sv
// Platform-table refresh sequencer.
// On start, walks every slot of the external platform RAM (read, wait, write),
// moves each platform down by the latched scroll distance and respawns platforms
// that fall off the bottom of the screen at a pseudo-random x. A one-cycle done
// pulse ends the pass.
// Optional feature macro: PLAT_SCORE_EN adds the 'score' output, a saturating
// total of scrolled pixels updated once per pass.
// Ports:
//   Clock, Reset_n : clock and synchronous active-low reset
//   start          : begin one pass (accepted only when idle)
//   scroll_dy      : scroll distance, latched on accepted start
//   plat_rd_addr   : RAM read address (0 outside the read cycle)
//   plat_rd_data   : RAM read data {x, y}, valid one cycle after the address
//   plat_we        : RAM write strobe, one cycle per slot
//   plat_wr_addr   : RAM write address
//   plat_wr_data   : RAM write data {x, y}
//   busy           : high whenever the sequencer is not idle
//   done           : one-cycle pulse at the end of a pass
//   score          : total scrolled pixels (PLAT_SCORE_EN only)
import doodle_pkg::*;

module plat_scroll_ctrl #(
  parameter int         NUM_PLAT  = 10,
  parameter int         SCREEN_H  = doodle_pkg::SCREEN_H,
  parameter int         X_MAX     = doodle_pkg::SCREEN_W - doodle_pkg::PLAT_W,
  parameter logic [9:0] LFSR_SEED = 10'h2A5,
  localparam int        IW        = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          start,
  input  logic [9:0]    scroll_dy,
  output logic [IW-1:0] plat_rd_addr,
  input  logic [19:0]   plat_rd_data,
  output logic          plat_we,
  output logic [IW-1:0] plat_wr_addr,
  output logic [19:0]   plat_wr_data,
  output logic          busy,
  output logic          done
`ifdef PLAT_SCORE_EN
  ,
  output logic [15:0]   score
`endif
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PLAT - 1);
  localparam logic [9:0]    DY_MAX   = 10'(SCREEN_H - 1);
  localparam logic [10:0]   H11      = 11'(SCREEN_H);

  psc_state_t    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [9:0]    dy_q, dy_d;
  plat_t         rd_q, rd_d;
  logic [9:0]    rnd;
  logic [10:0]   ny;
  plat_t         new_slot;

  plat_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .q       (rnd)
  );

  // Next-state logic of the pass sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dy_d    = dy_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dy_d    = clamp_dy(scroll_dy, DY_MAX);
          idx_d   = {IW{1'b0}};
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // RAM data for the current slot is valid now.
        rd_d    = plat_t'(plat_rd_data);
        state_d = WRITE;
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
          state_d = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= {IW{1'b0}};
      dy_q    <= 10'd0;
      rd_q    <= '{x: 10'd0, y: 10'd0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dy_q    <= dy_d;
      rd_q    <= rd_d;
    end
  end

  // New slot value: scroll down; past the bottom edge, wrap y and pick a random x.
  always_comb begin
    ny = {1'b0, rd_q.y} + {1'b0, dy_q};
    if (ny < H11) begin
      new_slot.x = rd_q.x;
      new_slot.y = ny[9:0];
    end else begin
      new_slot.x = wrap_x(rnd, 10'(X_MAX));
      new_slot.y = 10'(ny - H11);
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    plat_we      = (state_q == WRITE);
    plat_rd_addr = (state_q == READ) ? idx_q : {IW{1'b0}};
    if (state_q == WRITE) begin
      plat_wr_addr = idx_q;
      plat_wr_data = new_slot;
    end else begin
      plat_wr_addr = {IW{1'b0}};
      plat_wr_data = 20'd0;
    end
  end

`ifdef PLAT_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;

  // Saturating accumulation of the scroll distance, once per completed pass.
  always_comb begin
    score_sum = {1'b0, score_q} + {7'd0, dy_q};
    if (state_q == DONE) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end else begin
      score_d = score_q;
    end
  end

  // Score register, cleared only by reset.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      score_q <= 16'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_plat_scroll_ctrl.sv
// Self-checking bench for plat_scroll_ctrl with a behavioural platform RAM.
// Build with PLAT_SCORE_EN defined to include the score checks.
module tb_plat_scroll_ctrl;

  localparam int         N    = 10;
  localparam int         SH   = 480;
  localparam int         XM   = 576;
  localparam logic [9:0] SEED = 10'h2A5;
  localparam int         IW   = 4;

  logic          Clock;
  logic          Reset_n;
  logic          start;
  logic [9:0]    scroll_dy;
  logic [IW-1:0] plat_rd_addr;
  logic [19:0]   plat_rd_data;
  logic          plat_we;
  logic [IW-1:0] plat_wr_addr;
  logic [19:0]   plat_wr_data;
  logic          busy;
  logic          done;
`ifdef PLAT_SCORE_EN
  logic [15:0]   score;
`endif

  int errors;
  int checks;
  int exp_score;

  logic [19:0] mem      [N];
  logic [19:0] init_mem [N];
  logic        load_en;
  logic [9:0]  lref;

  plat_scroll_ctrl #(
    .NUM_PLAT  (N),
    .SCREEN_H  (SH),
    .X_MAX     (XM),
    .LFSR_SEED (SEED)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .start        (start),
    .scroll_dy    (scroll_dy),
    .plat_rd_addr (plat_rd_addr),
    .plat_rd_data (plat_rd_data),
    .plat_we      (plat_we),
    .plat_wr_addr (plat_wr_addr),
    .plat_wr_data (plat_wr_data),
    .busy         (busy),
    .done         (done)
`ifdef PLAT_SCORE_EN
    ,
    .score        (score)
`endif
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Platform RAM: one-cycle read latency, bulk load port for the bench.
  always @(posedge Clock) begin
    if (load_en) begin
      for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
    end else if (plat_we === 1'b1 && int'(plat_wr_addr) < N) begin
      mem[plat_wr_addr] <= plat_wr_data;
    end
    plat_rd_data <= (int'(plat_rd_addr) < N) ? mem[plat_rd_addr] : 20'hxxxxx;
  end

  // Reference random source: x^10+x^7+1 sequence restarted from the seed by reset.
  always @(posedge Clock) begin
    if (!Reset_n) lref <= SEED;
    else          lref <= {lref[8:0], lref[9] ^ lref[6]};
  end

  task automatic load_mem();
    @(negedge Clock);
    load_en = 1'b1;
    @(negedge Clock);
    load_en = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      init_mem[i] = {10'($urandom_range(0, XM)), 10'($urandom_range(0, SH - 1))};
  endtask

  // One full pass with cycle-accurate expectations; optional extra start pulses in cycles 5 and 31.
  task automatic run_pass(input logic [9:0] dy, input bit extra);
    logic [19:0] snap [N];
    logic [19:0] expv [N];
    logic [19:0] ev;
    logic [9:0]  dq;
    logic [9:0]  xr;
    logic        e_busy, e_done, e_we;
    int          ny, slot, e_rd, wes, dones;
    dq = (dy > 10'd479) ? 10'd479 : dy;
    for (int i = 0; i < N; i++) begin
      snap[i] = mem[i];
      expv[i] = mem[i];
    end
    wes = 0;
    dones = 0;
    @(negedge Clock);
    start = 1'b1;
    scroll_dy = dy;
    for (int c = 1; c <= 3 * N + 2; c++) begin
      @(negedge Clock);
      start = extra && (c == 5 || c == 3 * N + 1);
      scroll_dy = 10'($urandom);
      e_busy = (c <= 3 * N + 1);
      e_done = (c == 3 * N + 1);
      e_we   = (c % 3 == 0) && (c <= 3 * N);
      e_rd   = (c % 3 == 1 && c <= 3 * N - 2) ? (c - 1) / 3 : 0;
      if (plat_we === 1'b1) wes++;
      if (done === 1'b1) dones++;
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL busy cycle=%0d got=%b exp=%b", c, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        errors++;
        $display("FAIL done cycle=%0d got=%b exp=%b", c, done, e_done);
      end
      checks++;
      if (plat_we !== e_we) begin
        errors++;
        $display("FAIL plat_we cycle=%0d got=%b exp=%b", c, plat_we, e_we);
      end
      checks++;
      if (plat_rd_addr !== IW'(e_rd)) begin
        errors++;
        $display("FAIL rd_addr cycle=%0d got=%0d exp=%0d", c, plat_rd_addr, e_rd);
      end
      if (e_we) begin
        slot = c / 3 - 1;
        ny = int'(snap[slot][9:0]) + int'(dq);
        if (ny < SH) begin
          ev = {snap[slot][19:10], 10'(ny)};
        end else begin
          xr = (lref > 10'(XM)) ? (lref - 10'(XM + 1)) : lref;
          ev = {xr, 10'(ny - SH)};
        end
        expv[slot] = ev;
        checks++;
        if (plat_wr_addr !== IW'(slot)) begin
          errors++;
          $display("FAIL wr_addr cycle=%0d got=%0d exp=%0d", c, plat_wr_addr, slot);
        end
        checks++;
        if (plat_wr_data !== ev) begin
          errors++;
          $display("FAIL wr_data slot=%0d got=%h exp=%h", slot, plat_wr_data, ev);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (wes != N || dones != 1) begin
      errors++;
      $display("FAIL pulse_count we=%0d exp=%0d done=%0d exp=1", wes, N, dones);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[i] !== expv[i]) begin
        errors++;
        $display("FAIL ram slot=%0d got=%h exp=%h", i, mem[i], expv[i]);
      end
    end
    exp_score = (exp_score + int'(dq) > 65535) ? 65535 : exp_score + int'(dq);
`ifdef PLAT_SCORE_EN
    checks++;
    if (score !== 16'(exp_score)) begin
      errors++;
      $display("FAIL score got=%0d exp=%0d", score, exp_score);
    end
`endif
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if ({busy, done, plat_we, plat_rd_addr, plat_wr_addr, plat_wr_data} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b/%b/%b/%h/%h/%h exp=all zero",
               busy, done, plat_we, plat_rd_addr, plat_wr_addr, plat_wr_data);
    end
`ifdef PLAT_SCORE_EN
    checks++;
    if (score !== 16'd0) begin
      errors++;
      $display("FAIL reset_score got=%0d exp=0", score);
    end
`endif
    Reset_n = 1'b1;
    exp_score = 0;
    repeat (2) @(negedge Clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done);
    end
  endtask

  task automatic test_scroll_basic();
    for (int i = 0; i < N; i++) init_mem[i] = {10'($urandom_range(0, XM)), 10'd100};
    load_mem();
    run_pass(10'd20, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[i] !== {init_mem[i][19:10], 10'd120}) begin
        errors++;
        $display("FAIL basic_slot%0d got=%h exp=%h", i, mem[i], {init_mem[i][19:10], 10'd120});
      end
    end
  endtask

  task automatic test_respawn();
    for (int i = 0; i < N; i++) init_mem[i] = {10'($urandom_range(0, XM)), 10'd100};
    init_mem[3] = {10'd200, 10'd470};
    init_mem[4] = {10'd300, 10'd469};
    load_mem();
    run_pass(10'd10, 1'b0);
    checks++;
    if (mem[3][9:0] !== 10'd0 || mem[3][19:10] > 10'(XM)) begin
      errors++;
      $display("FAIL respawn_edge got=x%0d y%0d exp=x<=%0d y0", mem[3][19:10], mem[3][9:0], XM);
    end
    checks++;
    if (mem[4] !== {10'd300, 10'd479}) begin
      errors++;
      $display("FAIL no_respawn got=%h exp=%h", mem[4], {10'd300, 10'd479});
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < N; i++) init_mem[i] = {10'd400, 10'd200};
    init_mem[0] = {10'd50, 10'd5};
    init_mem[1] = {10'd60, 10'd0};
    load_mem();
    run_pass(10'd700, 1'b0);
    checks++;
    if (mem[0][9:0] !== 10'd4 || mem[0][19:10] > 10'(XM)) begin
      errors++;
      $display("FAIL clamp_respawn got=x%0d y%0d exp=y4", mem[0][19:10], mem[0][9:0]);
    end
    checks++;
    if (mem[1] !== {10'd60, 10'd479}) begin
      errors++;
      $display("FAIL clamp_keep got=%h exp=%h", mem[1], {10'd60, 10'd479});
    end
  endtask

  task automatic test_zero_dy();
    fill_random();
    load_mem();
    run_pass(10'd0, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[i] !== init_mem[i]) begin
        errors++;
        $display("FAIL zero_dy slot=%0d got=%h exp=%h", i, mem[i], init_mem[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    load_mem();
    run_pass(10'd33, 1'b1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      fill_random();
      load_mem();
      run_pass(10'($urandom_range(0, 1023)), 1'b0);
    end
  endtask

  task automatic test_midpass_reset();
    logic [19:0] expv [N];
    logic [9:0]  xr;
    int          ny, slot, bad;
    fill_random();
    load_mem();
    for (int i = 0; i < N; i++) expv[i] = init_mem[i];
    @(negedge Clock);
    start = 1'b1;
    scroll_dy = 10'd30;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clock);
      start = 1'b0;
      if (c == 3 || c == 6) begin
        slot = c / 3 - 1;
        ny = int'(init_mem[slot][9:0]) + 30;
        xr = (lref > 10'(XM)) ? (lref - 10'(XM + 1)) : lref;
        expv[slot] = (ny < SH) ? {init_mem[slot][19:10], 10'(ny)} : {xr, 10'(ny - SH)};
      end
      if (c == 8) Reset_n = 1'b0;
    end
    @(negedge Clock);
    checks++;
    if (busy !== 1'b0 || plat_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midpass busy=%b we=%b done=%b exp=0/0/0", busy, plat_we, done);
    end
    Reset_n = 1'b1;
    exp_score = 0;
    bad = 0;
    repeat (6) begin
      @(negedge Clock);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL after_midpass_reset active_cycles=%0d exp=0", bad);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[i] !== expv[i]) begin
        errors++;
        $display("FAIL midpass_ram slot=%0d got=%h exp=%h", i, mem[i], expv[i]);
      end
    end
  endtask

`ifdef PLAT_SCORE_EN
  task automatic test_score_saturate();
    repeat (140) run_pass(10'd479, 1'b0);
    checks++;
    if (score !== 16'hFFFF) begin
      errors++;
      $display("FAIL score_saturate got=%h exp=ffff", score);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    exp_score = 0;
    Reset_n = 1'b0;
    start = 1'b0;
    scroll_dy = 10'd0;
    load_en = 1'b0;
    for (int i = 0; i < N; i++) init_mem[i] = 20'd0;
    test_reset();
    test_scroll_basic();
    test_respawn();
    test_clamp();
    test_zero_dy();
    test_start_ignored();
    test_random();
    test_midpass_reset();
`ifdef PLAT_SCORE_EN
    test_score_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
